// File: rtl/tdoa_pkg.sv
// Shared word layout and widths for the TDOA capture path.
// The capture block packs words with pack_word(); the FIFO just stores them.
package tdoa_pkg;

    localparam int WORD_W   = 32;
    localparam int CH_MSB   = 31;
    localparam int CH_LSB   = 28;
    localparam int SEQ_MSB  = 27;
    localparam int SEQ_LSB  = 20;
    localparam int LOST_BIT = 19;
    localparam int ZERO_BIT = 18;
    localparam int VAL_MSB  = 17;
    localparam int VAL_LSB  = 0;
    localparam int DROP_W   = 16;

    localparam int CH_W    = CH_MSB - CH_LSB + 1;
    localparam int SEQ_W   = SEQ_MSB - SEQ_LSB + 1;
    localparam int VALUE_W = VAL_MSB - VAL_LSB + 1;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [CH_W-1:0]    ch,
        input logic [SEQ_W-1:0]   seq,
        input logic               lost,
        input logic [VALUE_W-1:0] value
    );
        logic [WORD_W-1:0] w;
        w                  = '0;
        w[CH_MSB:CH_LSB]   = ch;
        w[SEQ_MSB:SEQ_LSB] = seq;
        w[LOST_BIT]        = lost;
        w[ZERO_BIT]        = 1'b0;
        w[VAL_MSB:VAL_LSB] = value;
        return w;
    endfunction

endpackage

// File: rtl/tdoa_sync_fifo.sv
// Show-ahead synchronous FIFO; full and empty are told apart by the level count.
module tdoa_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   valid_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             wr_ok;
    logic             rd_ok;

    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign valid_o   = (level_q != '0);
    assign wr_ok     = wr_en_i && !full_o;
    assign rd_ok     = rd_en_i && valid_o;
    assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o   = level_q;

    // NOTE: storage is deliberately not reset; valid_o masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/tdoa_capture_fifo.sv
// Per-channel holding registers, round-robin arbiter and word packing
// in front of a show-ahead FIFO.
module tdoa_capture_fifo
    import tdoa_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNTR_W = 10,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*CNTR_W-1:0] cntr,
    input  logic [NUM_CH-1:0]        cntr_valid,
    output logic [WORD_W-1:0]        data_out,
    output logic                     data_out_valid,
    input  logic                     data_out_read,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]        drop_count
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CNTR_W-1:0] val_q [NUM_CH];
    logic [SEQ_W-1:0]  seq_q [NUM_CH];
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] lost_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [DROP_W-1:0] drop_q;
    logic [DROP_W-1:0] drop_d;

    logic              fifo_full;
    logic              grant_vld;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  cand;
    logic [NUM_CH-1:0] drop_vec;
    logic [DROP_W:0]   drop_sum;
    logic [WORD_W-1:0] wr_word;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = PTR_W'((i + int'(ptr_q)) % NUM_CH);
            if (!grant_vld && !fifo_full && pending_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // A strobe on a granted channel replaces a value already being written, so it is no drop.
    always_comb begin
        drop_vec = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            drop_vec[k] = cntr_valid[k] && pending_q[k]
                          && !(grant_vld && grant_idx == PTR_W'(k));
        end
        drop_sum = {1'b0, drop_q} + (DROP_W+1)'($countones(drop_vec));
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    assign wr_word = pack_word(CH_W'(grant_idx), seq_q[grant_idx], lost_q[grant_idx],
                               VALUE_W'(val_q[grant_idx]));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            lost_q    <= '0;
            ptr_q     <= '0;
            drop_q    <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                val_q[k] <= '0;
                seq_q[k] <= '0;
            end
        end else begin
            drop_q <= drop_d;
            if (grant_vld) begin
                ptr_q <= (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (grant_vld && grant_idx == PTR_W'(k)) begin
                    seq_q[k]     <= seq_q[k] + 1'b1;
                    pending_q[k] <= cntr_valid[k];
                    lost_q[k]    <= 1'b0;
                end else if (cntr_valid[k]) begin
                    pending_q[k] <= 1'b1;
                    lost_q[k]    <= lost_q[k] | pending_q[k];
                end
                if (cntr_valid[k]) val_q[k] <= cntr[k*CNTR_W +: CNTR_W];
            end
        end
    end

    assign drop_count = drop_q;

    tdoa_sync_fifo #(
        .WIDTH(WORD_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .wr_en_i  (grant_vld),
        .wr_data_i(wr_word),
        .rd_en_i  (data_out_read),
        .rd_data_o(data_out),
        .valid_o  (data_out_valid),
        .full_o   (fifo_full),
        .level_o  (fifo_level)
    );

endmodule

// File: tb/tb_tdoa_capture_fifo.sv
// Bench for tdoa_capture_fifo: fixed vector table, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_tdoa_capture_fifo;

    localparam int NUM_CH = 4;
    localparam int CNTR_W = 10;
    localparam int DEPTH  = 16;

    logic                     clk;
    logic                     rst;
    logic [NUM_CH*CNTR_W-1:0] cntr;
    logic [NUM_CH-1:0]        cntr_valid;
    logic [31:0]              data_out;
    logic                     data_out_valid;
    logic                     data_out_read;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic [15:0]              drop_count;

    tdoa_capture_fifo #(.NUM_CH(NUM_CH), .CNTR_W(CNTR_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .cntr          (cntr),
        .cntr_valid    (cntr_valid),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_read (data_out_read),
        .fifo_level    (fifo_level),
        .drop_count    (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel sample slots plus a queue of words.
    int          m_ptr;
    bit          m_pend [NUM_CH];
    bit          m_lost [NUM_CH];
    int          m_seq  [NUM_CH];
    int          m_val  [NUM_CH];
    int          m_drop;
    logic [31:0] mq [$];
    logic [31:0] popped [$];

    function automatic logic [31:0] make_word(input int ch, input int seq, input int lost, input int val);
        return (32'(ch) << 28) | (32'(seq) << 20) | (32'(lost) << 19) | 32'(val);
    endfunction

    function automatic logic [39:0] pack4(input int a, input int b, input int c, input int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    task automatic model_clear();
        m_ptr  = 0;
        m_drop = 0;
        mq.delete();
        for (int k = 0; k < NUM_CH; k++) begin
            m_pend[k] = 0; m_lost[k] = 0; m_seq[k] = 0; m_val[k] = 0;
        end
    endtask

    task automatic model_edge(input logic [3:0] v, input logic [39:0] vals, input logic rd);
        int g;
        logic [31:0] tmp;
        g = -1;
        if (mq.size() < DEPTH) begin
            for (int i = 0; i < NUM_CH; i++) begin
                int c;
                c = (m_ptr + i) % NUM_CH;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        if (rd && mq.size() > 0) tmp = mq.pop_front();
        if (g >= 0) begin
            mq.push_back(make_word(g, m_seq[g], int'(m_lost[g]), m_val[g]));
            m_seq[g]  = (m_seq[g] + 1) % 256;
            m_pend[g] = 0;
            m_lost[g] = 0;
            m_ptr     = (g + 1) % NUM_CH;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (v[k]) begin
                if (m_pend[k]) begin
                    m_lost[k] = 1;
                    if (m_drop < 65535) m_drop++;
                end
                m_pend[k] = 1;
                m_val[k]  = int'(vals[k*CNTR_W +: CNTR_W]);
            end
        end
    endtask

    task automatic compare_model();
        check("valid", 32'(data_out_valid), 32'(mq.size() != 0));
        check("level", 32'(fifo_level), 32'(mq.size()));
        check("drop", 32'(drop_count), 32'(m_drop));
        if (mq.size() != 0) check("data", data_out, mq[0]);
    endtask

    task automatic step(input logic [3:0] v, input logic [39:0] vals, input logic rd, input bit cmp);
        logic        pre_valid;
        logic [31:0] pre_word;
        cntr_valid    = v;
        cntr          = vals;
        data_out_read = rd;
        pre_valid     = data_out_valid;
        pre_word      = data_out;
        @(posedge clk);
        model_edge(v, vals, rd);
        #1;
        if (rd && pre_valid) popped.push_back(pre_word);
        if (cmp) compare_model();
    endtask

    task automatic reset_dut();
        rst           = 1'b0;
        cntr_valid    = '0;
        cntr          = '0;
        data_out_read = 1'b0;
        model_clear();
        #1;
        check("rst_valid", 32'(data_out_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && (mq.size() != 0 || m_pend.or() != 0); i++)
            step('0, '0, 1'b1, 1);
        check("drained", 32'(mq.size()), 32'd0);
    endtask

    task automatic fill_full();
        for (int i = 0; i < DEPTH; i++) step(4'b0001, pack4(i + 10, 0, 0, 0), 1'b0, 1);
        step('0, '0, 1'b0, 1);
        check("full_level", 32'(fifo_level), 32'(DEPTH));
    endtask

    typedef struct {
        bit          do_rst;
        logic [3:0]  v;
        logic [39:0] vals;
        bit          rd;
        bit          e_valid;
        int          e_level;
        logic [31:0] e_word;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input bit r, input logic [3:0] v, input logic [39:0] vals,
                                input bit rd, input bit ev, input int el, input logic [31:0] ew);
        vec_t t;
        t.do_rst = r; t.v = v; t.vals = vals; t.rd = rd;
        t.e_valid = ev; t.e_level = el; t.e_word = ew;
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
        $fatal(1);
    end

    initial begin
        int e;
        int cnt;
        logic [3:0] v;

        rst = 1'b0; cntr = '0; cntr_valid = '0; data_out_read = 1'b0;
        model_clear();
        #2;
        check("por_valid", 32'(data_out_valid), 32'd0);
        check("por_level", 32'(fifo_level), 32'd0);
        check("por_data", data_out, 32'd0);
        check("por_drop", 32'(drop_count), 32'd0);
        @(posedge clk); #1; rst = 1'b1;

        // ch0 800/200/800 spaced by two cycles, then four-way same-edge strobe.
        tbl.push_back(mk(1, 4'b0001, pack4(800, 0, 0, 0), 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0000, '0,                  0, 1, 1, 32'h0000_0320));
        tbl.push_back(mk(0, 4'b0001, pack4(200, 0, 0, 0), 0, 1, 1, 32'h0000_0320));
        tbl.push_back(mk(0, 4'b0000, '0,                  0, 1, 2, 32'h0000_0320));
        tbl.push_back(mk(0, 4'b0001, pack4(800, 0, 0, 0), 0, 1, 2, 32'h0000_0320));
        tbl.push_back(mk(0, 4'b0000, '0,                  0, 1, 3, 32'h0000_0320));
        tbl.push_back(mk(0, 4'b0000, '0,                  1, 1, 2, 32'h0010_00C8));
        tbl.push_back(mk(0, 4'b0000, '0,                  1, 1, 1, 32'h0020_0320));
        tbl.push_back(mk(0, 4'b0000, '0,                  1, 0, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0000, '0,                  1, 0, 0, 32'h0));
        tbl.push_back(mk(1, 4'b1111, pack4(1, 2, 3, 4),   0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 4'b0000, '0,                  0, 1, 1, 32'h0000_0001));
        tbl.push_back(mk(0, 4'b0000, '0,                  0, 1, 2, 32'h0000_0001));
        tbl.push_back(mk(0, 4'b0000, '0,                  0, 1, 3, 32'h0000_0001));
        tbl.push_back(mk(0, 4'b0000, '0,                  0, 1, 4, 32'h0000_0001));
        tbl.push_back(mk(0, 4'b0000, '0,                  1, 1, 3, 32'h1000_0002));
        tbl.push_back(mk(0, 4'b0000, '0,                  1, 1, 2, 32'h2000_0003));
        tbl.push_back(mk(0, 4'b0000, '0,                  1, 1, 1, 32'h3000_0004));
        tbl.push_back(mk(0, 4'b0000, '0,                  1, 0, 0, 32'h0));

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) reset_dut();
            step(tbl[i].v, tbl[i].vals, tbl[i].rd, 0);
            check($sformatf("tbl%0d_valid", i), 32'(data_out_valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].e_level));
            check($sformatf("tbl%0d_drop", i), 32'(drop_count), 32'd0);
            if (tbl[i].e_valid) check($sformatf("tbl%0d_word", i), data_out, tbl[i].e_word);
        end

        // Full FIFO: ch2 overwritten while blocked, then released by reads.
        reset_dut();
        fill_full();
        step(4'b0100, pack4(0, 0, 5, 0), 1'b0, 1);
        step(4'b0100, pack4(0, 0, 6, 0), 1'b0, 1);
        check("ovw_drop", 32'(drop_count), 32'd1);
        for (int i = 0; i < 3; i++) step('0, '0, 1'b0, 1);
        check("ovw_blocked", 32'(fifo_level), 32'(DEPTH));
        popped.delete();
        drain();
        check("ovw_last_word", popped[popped.size()-1], 32'h2008_0006);

        // Full FIFO, read held DEPTH+2 cycles while ch1 strobes every cycle.
        reset_dut();
        fill_full();
        popped.delete();
        for (int i = 0; i < DEPTH + 2; i++) step(4'b0010, pack4(0, i, 0, 0), 1'b1, 1);
        drain();
        step('0, '0, 1'b1, 1);
        e = 0; cnt = 0;
        foreach (popped[i]) begin
            if (popped[i][31:28] == 4'd1) begin
                check("ch1_seq", 32'(popped[i][27:20]), 32'(e));
                e = (e + 1) % 256;
                cnt++;
            end
        end
        check("ch1_count", 32'(cnt), 32'(DEPTH + 2));

        // Reset with queued words and ch3 pending.
        reset_dut();
        for (int i = 0; i < 5; i++) step(4'b0001, pack4(i, 0, 0, 0), 1'b0, 1);
        step('0, '0, 1'b0, 1);
        step(4'b1000, pack4(0, 0, 0, 99), 1'b0, 1);
        check("pre_rst_level", 32'(fifo_level), 32'd5);
        rst = 1'b0;
        model_clear();
        #1;
        check("async_valid", 32'(data_out_valid), 32'd0);
        check("async_level", 32'(fifo_level), 32'd0);
        check("async_data", data_out, 32'd0);
        @(posedge clk); #1; rst = 1'b1;
        step(4'b1000, pack4(0, 0, 0, 77), 1'b0, 1);
        step('0, '0, 1'b0, 1);
        check("post_rst_ch3", data_out, 32'h3000_004D);

        // 300 words on ch0 with continuous reads: seq wraps without gaps.
        reset_dut();
        popped.delete();
        for (int i = 0; i < 300; i++) step(4'b0001, pack4(i % 1024, 0, 0, 0), 1'b1, 1);
        drain();
        check("wrap_count", 32'(popped.size()), 32'd300);
        foreach (popped[i]) check("wrap_seq", 32'(popped[i][27:20]), 32'(i % 256));

        // Random traffic: sparse reads first to hit full, then balanced.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NUM_CH; k++) v[k] = ($urandom_range(0, 2) == 0);
            step(v, 40'({$urandom, $urandom}),
                 (c < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0), 1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
